// File: rtl/ms6205_write_arbiter_if.sv
// Write-request and display-strobe bundle between requesters, display and the arbiter.
// The arbiter connects through the slave modport; the requester/display side uses master.
interface ms6205_write_arbiter_if;
   logic [2:0]  req;
   logic [23:0] req_addr;
   logic [23:0] req_data;
   logic        clear;
   logic        ready;
   logic [2:0]  ack;
   logic        err;
   logic        busy;
   logic [7:0]  address;
   logic [7:0]  data;
   logic        write_addr;
   logic        write_data;

   modport slave (
      input  req, req_addr, req_data, clear, ready,
      output ack, err, busy, address, data, write_addr, write_data
   );

   modport master (
      output req, req_addr, req_data, clear, ready,
      input  ack, err, busy, address, data, write_addr, write_data
   );
endinterface

// File: rtl/ms6205_write_arbiter.sv
// Three-way round-robin write arbiter for the MS6205 display with priority blank sweep.
// Six cycles grant-to-ack with ready high; waits on ready up to TIMEOUT cycles, then errors out.
module ms6205_write_arbiter #(
   parameter int         CELLS   = 160,
   parameter int         TIMEOUT = 15,
   parameter logic [7:0] BLANK   = 8'h20
) (
   input logic                   Clock_1ms,
   input logic                   Rst_n,
   ms6205_write_arbiter_if.slave bus
);

   localparam logic [8:0] LP_CELLS     = 9'(CELLS);
   localparam logic [7:0] LP_LAST_CELL = 8'(CELLS - 1);
   localparam logic [3:0] LP_WAIT_LAST = 4'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT_A,
      S_DATA,
      S_WAIT_D,
      S_DONE
   } state_t;

   state_t      r_state, w_state;
   logic [1:0]  r_ptr, w_ptr;
   logic [1:0]  r_cur, w_cur;
   logic        r_is_sweep, w_is_sweep;
   logic        r_flag, w_flag;
   logic        r_clr_pend, w_clr_pend;
   logic [7:0]  r_sweep_cnt, w_sweep_cnt;
   logic [3:0]  r_wait, w_wait;
   logic [2:0]  r_ack, w_ack;
   logic        r_err, w_err;
   logic [7:0]  r_addr, w_addr;
   logic [7:0]  r_data, w_data;
   logic        r_wa, w_wa;
   logic        r_wd, w_wd;

   logic        w_gnt_vld;
   logic [1:0]  w_gnt_idx;
   logic [1:0]  w_scan;
   logic [7:0]  w_sel_addr;
   logic [6:0]  w_sel_data;

   function automatic logic [1:0] f_rr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Scan starts one past the last granted requester.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = 2'd0;
      w_scan    = r_ptr;
      for (int k = 0; k < 3; k++) begin
         w_scan = f_rr_next(w_scan);
         if (!w_gnt_vld && bus.req[w_scan]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_scan;
         end
      end
   end

   always_comb begin
      w_sel_addr = bus.req_addr[7:0];
      w_sel_data = bus.req_data[6:0];
      case (w_gnt_idx)
         2'd1: begin
            w_sel_addr = bus.req_addr[15:8];
            w_sel_data = bus.req_data[14:8];
         end
         2'd2: begin
            w_sel_addr = bus.req_addr[23:16];
            w_sel_data = bus.req_data[22:16];
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state     = r_state;
      w_ptr       = r_ptr;
      w_cur       = r_cur;
      w_is_sweep  = r_is_sweep;
      w_flag      = r_flag;
      w_clr_pend  = r_clr_pend | bus.clear;
      w_sweep_cnt = r_sweep_cnt;
      w_wait      = r_wait;
      w_ack       = 3'b000;
      w_err       = 1'b0;
      w_addr      = r_addr;
      w_data      = r_data;
      w_wa        = 1'b0;
      w_wd        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.ready) begin
               if (r_clr_pend) begin
                  w_is_sweep = 1'b1;
                  w_flag     = 1'b0;
                  w_addr     = r_sweep_cnt;
                  w_data     = {1'b0, BLANK[6:0]};
                  w_wa       = 1'b1;
                  w_state    = S_ADDR;
               end else if (w_gnt_vld) begin
                  w_is_sweep = 1'b0;
                  w_cur      = w_gnt_idx;
                  w_addr     = w_sel_addr;
                  w_data     = {1'b0, w_sel_data};
                  if ({1'b0, w_sel_addr} >= LP_CELLS) begin
                     w_flag  = 1'b1;
                     w_state = S_DONE;
                  end else begin
                     w_flag  = 1'b0;
                     w_wa    = 1'b1;
                     w_state = S_ADDR;
                  end
               end
            end
         end
         S_ADDR: begin
            w_wait  = 4'd0;
            w_state = S_WAIT_A;
         end
         S_WAIT_A: begin
            if (bus.ready) begin
               w_wd    = 1'b1;
               w_state = S_DATA;
            end else if (r_wait == LP_WAIT_LAST) begin
               w_flag  = 1'b1;
               w_state = S_DONE;
            end else begin
               w_wait = r_wait + 4'd1;
            end
         end
         S_DATA: begin
            w_wait  = 4'd0;
            w_state = S_WAIT_D;
         end
         S_WAIT_D: begin
            if (bus.ready) begin
               w_state = S_DONE;
            end else if (r_wait == LP_WAIT_LAST) begin
               w_flag  = 1'b1;
               w_state = S_DONE;
            end else begin
               w_wait = r_wait + 4'd1;
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
            if (r_is_sweep) begin
               if (r_sweep_cnt == LP_LAST_CELL) begin
                  w_sweep_cnt = 8'd0;
                  w_clr_pend  = 1'b0;
               end else begin
                  w_sweep_cnt = r_sweep_cnt + 8'd1;
               end
            end else begin
               w_ptr = r_cur;
            end
         end
         default: w_state = S_IDLE;
      endcase

      // Completion pulses are registered so they are visible during the DONE cycle itself.
      if (w_state == S_DONE) begin
         if (!w_is_sweep) begin
            w_ack = 3'b001 << w_cur;
         end
         w_err = w_flag;
      end
   end

   always_ff @(posedge Clock_1ms) begin
      if (!Rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= 2'd2;
         r_cur       <= 2'd0;
         r_is_sweep  <= 1'b0;
         r_flag      <= 1'b0;
         r_clr_pend  <= 1'b1;
         r_sweep_cnt <= 8'd0;
         r_wait      <= 4'd0;
         r_ack       <= 3'b000;
         r_err       <= 1'b0;
         r_addr      <= 8'd0;
         r_data      <= 8'd0;
         r_wa        <= 1'b0;
         r_wd        <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_ptr       <= w_ptr;
         r_cur       <= w_cur;
         r_is_sweep  <= w_is_sweep;
         r_flag      <= w_flag;
         r_clr_pend  <= w_clr_pend;
         r_sweep_cnt <= w_sweep_cnt;
         r_wait      <= w_wait;
         r_ack       <= w_ack;
         r_err       <= w_err;
         r_addr      <= w_addr;
         r_data      <= w_data;
         r_wa        <= w_wa;
         r_wd        <= w_wd;
      end
   end

   assign bus.ack        = r_ack;
   assign bus.err        = r_err;
   assign bus.busy       = (r_state != S_IDLE) | r_clr_pend;
   assign bus.address    = r_addr;
   assign bus.data       = r_data;
   assign bus.write_addr = r_wa;
   assign bus.write_data = r_wd;

endmodule

// File: tb/tb_ms6205_write_arbiter.sv
// Directed bench for ms6205_write_arbiter: reset sweep, round-robin, bad address, timeout,
// clear during a transaction and reset mid-transaction.
module tb_ms6205_write_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   ms6205_write_arbiter_if bus_if ();

   ms6205_write_arbiter #(
      .CELLS   (160),
      .TIMEOUT (15),
      .BLANK   (8'h20)
   ) dut (
      .Clock_1ms (clk),
      .Rst_n     (rst_n),
      .bus       (bus_if)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Steps until an ack pulse (bounded); cyc counts edges from the first edge after the call.
   task automatic wait_ack(output logic [2:0] a, output logic e, output int cyc,
                           output int nwa, output int nwd,
                           output logic [7:0] wa_addr, output logic [7:0] wd_data);
      a = 3'b000; e = 1'b0; cyc = 0; nwa = 0; nwd = 0; wa_addr = 8'h00; wd_data = 8'h00;
      while (cyc < 200) begin
         step();
         cyc++;
         if (bus_if.write_addr) begin
            nwa++;
            wa_addr = bus_if.address;
         end
         if (bus_if.write_data) begin
            nwd++;
            wd_data = bus_if.data;
         end
         if (bus_if.ack != 3'b000) begin
            a = bus_if.ack;
            e = bus_if.err;
            break;
         end
      end
   endtask

   // Runs until busy drops (bounded), checking each sweep strobe against the expected cell.
   task automatic run_sweep(output int nwa, output int nwd, output int nack,
                            output int nbad, output logic idle_seen);
      nwa = 0; nwd = 0; nack = 0; nbad = 0; idle_seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         step();
         if (bus_if.write_addr) begin
            if (bus_if.address !== 8'(nwa)) nbad++;
            nwa++;
         end
         if (bus_if.write_data) begin
            if (bus_if.data !== 8'h20) nbad++;
            nwd++;
         end
         if (bus_if.ack != 3'b000) nack++;
         if (!bus_if.busy) begin
            idle_seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      logic [2:0] a;
      logic       e;
      int         cyc, nwa, nwd, nack, nbad;
      logic [7:0] wa_addr, wd_data;
      logic       idle_seen;
      logic       found;
      logic [2:0] exp_ack [6];
      exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

      rst_n              = 1'b0;
      bus_if.req         = 3'b000;
      bus_if.req_addr    = 24'h0;
      bus_if.req_data    = 24'h0;
      bus_if.clear       = 1'b0;
      bus_if.ready       = 1'b1;
      step();
      step();
      chk("rst_ack",  32'(bus_if.ack), 32'h0);
      chk("rst_err",  32'(bus_if.err), 32'h0);
      chk("rst_wa",   32'(bus_if.write_addr), 32'h0);
      chk("rst_wd",   32'(bus_if.write_data), 32'h0);
      chk("rst_addr", 32'(bus_if.address), 32'h0);
      chk("rst_data", 32'(bus_if.data), 32'h0);
      chk("rst_busy", 32'(bus_if.busy), 32'h1);

      // Power-on blank sweep over all 160 cells.
      rst_n = 1'b1;
      run_sweep(nwa, nwd, nack, nbad, idle_seen);
      chk("sweep_idle", 32'(idle_seen), 32'h1);
      chk("sweep_nwa",  32'(nwa), 32'd160);
      chk("sweep_nwd",  32'(nwd), 32'd160);
      chk("sweep_bad",  32'(nbad), 32'd0);
      chk("sweep_ack",  32'(nack), 32'd0);

      // All three request together; two full rounds in order 0,1,2.
      bus_if.req_addr = {8'd12, 8'd11, 8'd10};
      bus_if.req_data = {8'hC3, 8'h42, 8'h41};
      bus_if.req      = 3'b111;
      for (int t = 0; t < 6; t++) begin
         wait_ack(a, e, cyc, nwa, nwd, wa_addr, wd_data);
         chk($sformatf("rr_ack%0d", t), 32'(a), 32'(exp_ack[t]));
         chk($sformatf("rr_lat%0d", t), 32'(cyc), (t == 0) ? 32'd5 : 32'd6);
         chk($sformatf("rr_err%0d", t), 32'(e), 32'h0);
         chk($sformatf("rr_addr%0d", t), 32'(wa_addr), 32'd10 + 32'(t % 3));
         chk($sformatf("rr_data%0d", t), 32'(wd_data), (t % 3 == 2) ? 32'h43 : 32'h41 + 32'(t % 3));
      end
      bus_if.req = 3'b000;
      step();

      // Out-of-range cell: no strobes, ack and err in the cycle right after the grant edge.
      bus_if.req_addr = {8'd12, 8'd200, 8'd10};
      bus_if.req      = 3'b010;
      wait_ack(a, e, cyc, nwa, nwd, wa_addr, wd_data);
      chk("bad_ack", 32'(a), 32'h2);
      chk("bad_err", 32'(e), 32'h1);
      chk("bad_lat", 32'(cyc), 32'd1);
      chk("bad_nwa", 32'(nwa), 32'd0);
      chk("bad_nwd", 32'(nwd), 32'd0);
      bus_if.req = 3'b000;
      step();

      // Display stalls after the address strobe: 15 WAIT_A cycles then error completion.
      bus_if.req_addr = {8'd12, 8'd11, 8'd5};
      bus_if.req      = 3'b001;
      step();
      chk("to_wa", 32'(bus_if.write_addr), 32'h1);
      bus_if.ready = 1'b0;
      wait_ack(a, e, cyc, nwa, nwd, wa_addr, wd_data);
      chk("to_ack", 32'(a), 32'h1);
      chk("to_err", 32'(e), 32'h1);
      chk("to_lat", 32'(cyc), 32'd16);
      chk("to_nwd", 32'(nwd), 32'd0);
      bus_if.ready = 1'b1;
      bus_if.req   = 3'b000;
      step();

      // Clear while requester 2 is in flight; requester 0 waits behind the sweep.
      bus_if.req_addr = {8'd30, 8'd11, 8'd5};
      bus_if.req_data = {8'h55, 8'h42, 8'h41};
      bus_if.req      = 3'b100;
      step();
      bus_if.clear = 1'b1;
      bus_if.req   = 3'b101;
      step();
      bus_if.clear = 1'b0;
      chk("clr_busy", 32'(bus_if.busy), 32'h1);
      wait_ack(a, e, cyc, nwa, nwd, wa_addr, wd_data);
      chk("clr_ack2", 32'(a), 32'h4);
      chk("clr_lat",  32'(cyc), 32'd3);
      chk("clr_data", 32'(wd_data), 32'h55);
      bus_if.req = 3'b001;
      run_sweep(nwa, nwd, nack, nbad, idle_seen);
      chk("clr_idle", 32'(idle_seen), 32'h1);
      chk("clr_nwa",  32'(nwa), 32'd160);
      chk("clr_bad",  32'(nbad), 32'd0);
      chk("clr_nack", 32'(nack), 32'd0);
      wait_ack(a, e, cyc, nwa, nwd, wa_addr, wd_data);
      chk("clr_ack0", 32'(a), 32'h1);
      chk("clr_lat0", 32'(cyc), 32'd5);
      bus_if.req = 3'b000;
      step();

      // Reset while the FSM sits in WAIT_D.
      bus_if.req_addr = {8'd30, 8'd7, 8'd5};
      bus_if.req_data = {8'h55, 8'h11, 8'h41};
      bus_if.req      = 3'b010;
      step();
      step();
      step();
      chk("mid_wd", 32'(bus_if.write_data), 32'h1);
      bus_if.ready = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      chk("mid_ack",  32'(bus_if.ack), 32'h0);
      chk("mid_err",  32'(bus_if.err), 32'h0);
      chk("mid_wa",   32'(bus_if.write_addr), 32'h0);
      chk("mid_wd0",  32'(bus_if.write_data), 32'h0);
      chk("mid_addr", 32'(bus_if.address), 32'h0);
      chk("mid_data", 32'(bus_if.data), 32'h0);
      chk("mid_busy", 32'(bus_if.busy), 32'h1);
      rst_n        = 1'b1;
      bus_if.ready = 1'b1;
      bus_if.req   = 3'b000;
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus_if.write_addr) begin
            found = 1'b1;
            break;
         end
      end
      chk("re_wa_seen", 32'(found), 32'h1);
      chk("re_addr",    32'(bus_if.address), 32'h0);
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus_if.write_data) begin
            found = 1'b1;
            break;
         end
      end
      chk("re_wd_seen", 32'(found), 32'h1);
      chk("re_data",    32'(bus_if.data), 32'h20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
